// File: rtl/fifo_sp_ctrl_pkg.sv
// Shared types and helpers for the single-port-RAM FIFO controller.
//   state_e   : controller port-sequencing state
//   GRANT_*   : encoding of the arbiter's last_grant register
//   cnt_width : width of an occupancy counter for a given address width
package fifo_sp_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      RD_CAP = 1'b1
   } state_e;

   localparam logic GRANT_WR = 1'b0;
   localparam logic GRANT_RD = 1'b1;

   // One extra bit so a completely full RAM can be represented.
   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_sp_ctrl_if.sv
// Valid/ready push and pop handshake of the FIFO controller.
//   wr_valid/wr_ready/wr_data : push side
//   rd_valid/rd_ready/rd_data : pop side (rd_data is the registered head)
//   master : FIFO user, slave : FIFO controller
interface fifo_sp_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (output wr_valid, wr_data, rd_ready,
                   input  wr_ready, rd_valid, rd_data);

   modport slave  (input  wr_valid, wr_data, rd_ready,
                   output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/fifo_sp_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (write vs. read) for the RAM port.
//   clk, reset          : clock, async active-high reset
//   req_wr_i, req_rd_i  : requests
//   advance_i           : a grant was taken this cycle; remember the winner
//   gnt_wr_o, gnt_rd_o  : one-hot (or zero) grant
module rr_arb2
   import fifo_sp_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_wr_i,
   input  logic req_rd_i,
   input  logic advance_i,
   output logic gnt_wr_o,
   output logic gnt_rd_o
);

   logic last_grant_q, last_grant_d;

   // On a tie the side that did not win last time gets the port.
   assign gnt_wr_o = req_wr_i && (!req_rd_i || (last_grant_q == GRANT_RD));
   assign gnt_rd_o = req_rd_i && !gnt_wr_o;

   always_comb begin
      last_grant_d = last_grant_q;
      if (advance_i) begin
         last_grant_d = gnt_wr_o ? GRANT_WR : GRANT_RD;
      end
   end

   // Reset value makes the write side win the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= GRANT_RD;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/ram_sp_sr_sw.sv
// Single-port RAM, synchronous read and write, shared bidirectional bus.
//   address, cs, we : write on cs&&we, read-register load on cs&&!we
//   oe              : drives the read register onto data when cs&&oe&&!we
//   data            : bidirectional data bus
module ram_sp_sr_sw #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  cs,
   input  logic                  we,
   input  logic                  oe,
   inout  wire  [DATA_WIDTH-1:0] data
);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (cs && we) begin
         mem[address] <= data;
      end
      if (cs && !we) begin
         rdata_q <= mem[address];
      end
   end

   assign data = (cs && oe && !we) ? rdata_q : 'z;

endmodule

// File: rtl/fifo_sp_ctrl.sv
// FIFO controller sequencing one single-port synchronous-read RAM.
// Each cycle the RAM port goes to a push or to a prefetch into a one-entry
// output register; a prefetch takes an issue cycle plus a capture cycle.
//   clk, reset        : clock, async active-high reset
//   bus (slave)       : push/pop valid/ready handshake
//   count, full, empty: occupancy (RAM entries + output register)
//   ram_addr/cs/we/oe : RAM control
//   ram_data          : RAM bus, driven with wr_data only during writes
module fifo_sp_ctrl
   import fifo_sp_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   fifo_sp_ctrl_if.slave                      bus,
   output logic [cnt_width(ADDR_WIDTH)-1:0]   count,
   output logic                               full,
   output logic                               empty,
   output logic [ADDR_WIDTH-1:0]              ram_addr,
   output logic                               ram_cs,
   output logic                               ram_we,
   output logic                               ram_oe,
   inout  wire  [DATA_WIDTH-1:0]              ram_data
);

   localparam int CW = cnt_width(ADDR_WIDTH);

   typedef logic [ADDR_WIDTH-1:0] ptr_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(RAM_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic ptr_t ptr_dec(input ptr_t p);
      return (p == '0) ? ptr_t'(RAM_DEPTH - 1) : p - 1'b1;
   endfunction

   state_e                state_q, state_d;
   ptr_t                  wptr_q, wptr_d;
   ptr_t                  rptr_q, rptr_d;
   logic [CW-1:0]         ram_count_q, ram_count_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic pop, need_rd, req_wr, req_rd, gnt_wr, gnt_rd;

   assign full    = (ram_count_q == CW'(RAM_DEPTH));
   assign pop     = out_valid_q && bus.rd_ready;
   // Prefetch whenever the output register is free or is being emptied now.
   assign need_rd = (ram_count_q != '0) && (!out_valid_q || pop);
   assign req_wr  = (state_q == IDLE) && bus.wr_valid && !full;
   assign req_rd  = (state_q == IDLE) && need_rd;

   rr_arb2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_wr_i  (req_wr),
      .req_rd_i  (req_rd),
      .advance_i (gnt_wr || gnt_rd),
      .gnt_wr_o  (gnt_wr),
      .gnt_rd_o  (gnt_rd)
   );

   // Port sequencing and pointer/count next state.
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      ram_count_d = ram_count_q;
      ram_cs      = 1'b0;
      ram_we      = 1'b0;
      ram_oe      = 1'b0;
      ram_addr    = wptr_q;
      case (state_q)
         IDLE: begin
            if (gnt_wr) begin
               ram_cs      = 1'b1;
               ram_we      = 1'b1;
               ram_addr    = wptr_q;
               wptr_d      = ptr_inc(wptr_q);
               ram_count_d = ram_count_q + 1'b1;
            end else if (gnt_rd) begin
               ram_cs      = 1'b1;
               ram_oe      = 1'b1;
               ram_addr    = rptr_q;
               rptr_d      = ptr_inc(rptr_q);
               ram_count_d = ram_count_q - 1'b1;
               state_d     = RD_CAP;
            end
         end
         RD_CAP: begin
            // rptr already advanced at issue; keep the RAM on the same word.
            ram_cs   = 1'b1;
            ram_oe   = 1'b1;
            ram_addr = ptr_dec(rptr_q);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         ram_cs = 1'b0;
         ram_we = 1'b0;
         ram_oe = 1'b0;
      end
   end

   // Output register: a capture on the same edge as a pop takes priority.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (state_q == RD_CAP) begin
         out_valid_d = 1'b1;
         out_data_d  = ram_data;
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         ram_count_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ram_count_q <= ram_count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign ram_data     = (ram_cs && ram_we) ? bus.wr_data : 'z;
   assign bus.wr_ready = gnt_wr && !reset;
   assign bus.rd_valid = out_valid_q;
   assign bus.rd_data  = out_data_q;
   assign count        = ram_count_q + CW'(out_valid_q);
   assign empty        = (count == '0);

endmodule

// File: tb/tb_fifo_sp_ctrl.sv
// Bench for fifo_sp_ctrl paired with ram_sp_sr_sw (ADDR_WIDTH=2, 4 RAM words).
module tb_fifo_sp_ctrl;

   localparam int AW = 2;
   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic [AW:0]   count;
   logic          full, empty;
   logic [AW-1:0] ram_addr;
   logic          ram_cs, ram_we, ram_oe;
   wire  [DW-1:0] ram_data;

   fifo_sp_ctrl_if #(.DATA_WIDTH(DW)) ifc ();

   fifo_sp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .bus(ifc.slave), .count(count), .full(full),
      .empty(empty), .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we),
      .ram_oe(ram_oe), .ram_data(ram_data)
   );

   ram_sp_sr_sw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
      .clk(clk), .address(ram_addr), .cs(ram_cs), .we(ram_we), .oe(ram_oe),
      .data(ram_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard: words accepted on push and words delivered on pop, in order.
   logic [DW-1:0] pushed[$];
   logic [DW-1:0] popped[$];

   logic          smp_wr_ready, smp_rd_valid, smp_full, smp_empty;
   logic          smp_cs, smp_we, smp_oe;
   logic [DW-1:0] smp_rd_data, smp_bus;
   logic [AW:0]   smp_count;
   logic [AW-1:0] smp_addr;
   int            smp_size;

   // One clock cycle: sample mid-cycle, log handshakes, return just after the edge.
   task automatic cyc();
      @(negedge clk);
      smp_wr_ready = ifc.wr_ready;
      smp_rd_valid = ifc.rd_valid;
      smp_rd_data  = ifc.rd_data;
      smp_count    = count;
      smp_full     = full;
      smp_empty    = empty;
      smp_cs       = ram_cs;
      smp_we       = ram_we;
      smp_oe       = ram_oe;
      smp_addr     = ram_addr;
      smp_bus      = ram_data;
      smp_size     = pushed.size() - popped.size();
      if (ifc.wr_valid && ifc.wr_ready) pushed.push_back(ifc.wr_data);
      if (ifc.rd_valid && ifc.rd_ready) popped.push_back(ifc.rd_data);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      ifc.wr_valid = 1'b0;
      ifc.rd_ready = 1'b0;
      ifc.wr_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      pushed.delete();
      popped.delete();
   endtask

   task automatic push_word(input logic [DW-1:0] d, output bit ok);
      int n0 = pushed.size();
      ok = 1'b0;
      ifc.wr_valid = 1'b1;
      ifc.wr_data  = d;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (pushed.size() != n0) begin
            ok = 1'b1;
            break;
         end
      end
      ifc.wr_valid = 1'b0;
   endtask

   task automatic wait_rdv(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (smp_rd_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      ifc.wr_valid = 1'b1;
      ifc.wr_data  = 8'h77;
      ifc.rd_ready = 1'b1;
      cyc();
      checks++;
      if (smp_wr_ready !== 1'b0) begin
         errors++; $display("FAIL rst_wr_ready got=%b exp=0", smp_wr_ready);
      end
      checks++;
      if (smp_rd_valid !== 1'b0 || smp_rd_data !== 8'h00) begin
         errors++; $display("FAIL rst_rd got=%b/%h exp=0/00", smp_rd_valid, smp_rd_data);
      end
      checks++;
      if (smp_count !== 3'd0 || smp_empty !== 1'b1 || smp_full !== 1'b0) begin
         errors++;
         $display("FAIL rst_status count=%0d empty=%b full=%b exp=0/1/0", smp_count, smp_empty, smp_full);
      end
      checks++;
      if ({smp_cs, smp_we, smp_oe} !== 3'b000) begin
         errors++; $display("FAIL rst_ram_ctl got=%b exp=000", {smp_cs, smp_we, smp_oe});
      end
      do_reset();
   endtask

   task automatic test_latency();
      do_reset();
      ifc.wr_valid = 1'b1;
      ifc.wr_data  = 8'hA5;
      cyc();
      ifc.wr_valid = 1'b0;
      checks++;
      if (smp_wr_ready !== 1'b1 || {smp_cs, smp_we, smp_oe} !== 3'b110 || smp_addr !== 2'd0) begin
         errors++;
         $display("FAIL lat_write rdy=%b ctl=%b addr=%0d exp=1/110/0", smp_wr_ready, {smp_cs, smp_we, smp_oe}, smp_addr);
      end
      checks++;
      if (smp_bus !== 8'hA5) begin
         errors++; $display("FAIL lat_bus got=%h exp=a5", smp_bus);
      end
      cyc();
      checks++;
      if (smp_rd_valid !== 1'b0 || {smp_cs, smp_we, smp_oe} !== 3'b101 || smp_addr !== 2'd0) begin
         errors++;
         $display("FAIL lat_issue rv=%b ctl=%b addr=%0d exp=0/101/0", smp_rd_valid, {smp_cs, smp_we, smp_oe}, smp_addr);
      end
      cyc();
      checks++;
      if (smp_rd_valid !== 1'b0 || {smp_cs, smp_we} !== 2'b10) begin
         errors++; $display("FAIL lat_capture rv=%b cs_we=%b exp=0/10", smp_rd_valid, {smp_cs, smp_we});
      end
      cyc();
      checks++;
      if (smp_rd_valid !== 1'b1 || smp_rd_data !== 8'hA5) begin
         errors++; $display("FAIL lat_out rv=%b data=%h exp=1/a5", smp_rd_valid, smp_rd_data);
      end
      checks++;
      if (smp_count !== 3'd1 || smp_empty !== 1'b0) begin
         errors++; $display("FAIL lat_count count=%0d empty=%b exp=1/0", smp_count, smp_empty);
      end
   endtask

   task automatic test_fill();
      bit ok;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         push_word(8'(i), ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL fill_push_timeout word=%0d got=no_ready exp=ready", i);
         end
      end
      cyc();
      checks++;
      if (smp_full !== 1'b1 || smp_count !== 3'd5 || smp_empty !== 1'b0) begin
         errors++;
         $display("FAIL fill_status full=%b count=%0d empty=%b exp=1/5/0", smp_full, smp_count, smp_empty);
      end
      checks++;
      if (smp_rd_valid !== 1'b1 || smp_rd_data !== 8'h01) begin
         errors++; $display("FAIL fill_head rv=%b data=%h exp=1/01", smp_rd_valid, smp_rd_data);
      end
      ifc.wr_valid = 1'b1;
      ifc.wr_data  = 8'h66;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (smp_wr_ready !== 1'b0 || smp_cs !== 1'b0) begin
            errors++; $display("FAIL fill_blocked rdy=%b cs=%b exp=0/0", smp_wr_ready, smp_cs);
         end
      end
      ifc.wr_valid = 1'b0;
   endtask

   // Continues from the full state left by test_fill.
   task automatic test_drain();
      int n = 0;
      ifc.rd_ready = 1'b1;
      while (popped.size() < 5 && n < 30) begin
         cyc();
         n++;
      end
      ifc.rd_ready = 1'b0;
      checks++;
      if (popped.size() != 5) begin
         errors++; $display("FAIL drain_count got=%0d exp=5", popped.size());
      end
      for (int i = 0; i < popped.size(); i++) begin
         checks++;
         if (popped[i] !== 8'(i + 1)) begin
            errors++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, popped[i], 8'(i + 1));
         end
      end
      checks++;
      if (n != 9) begin
         errors++; $display("FAIL drain_rate cycles=%0d exp=9", n);
      end
      cyc();
      checks++;
      if (smp_empty !== 1'b1 || smp_count !== 3'd0 || smp_rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty empty=%b count=%0d rv=%b exp=1/0/0", smp_empty, smp_count, smp_rd_valid);
      end
   endtask

   // Grant classes: 0 none, 1 write, 2 read issue, 3 read capture.
   task automatic test_arbitration();
      bit wv_t [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
      bit rr_t [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
      int ex_t [13] = '{1, 2, 3, 1, 2, 3, 1, 1, 2, 3, 1, 2, 3};
      int prev = 0;
      int cls;
      int n = 0;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         ifc.wr_valid = wv_t[i];
         ifc.rd_ready = rr_t[i];
         ifc.wr_data  = 8'($urandom);
         cyc();
         if (smp_cs && smp_we)       cls = 1;
         else if (smp_cs && !smp_we) cls = (prev == 2) ? 3 : 2;
         else                        cls = 0;
         checks++;
         if (cls != ex_t[i]) begin
            errors++; $display("FAIL arb_grant cycle=%0d got=%0d exp=%0d", i, cls, ex_t[i]);
         end
         checks++;
         if (smp_wr_ready !== (ex_t[i] == 1)) begin
            errors++; $display("FAIL arb_wr_ready cycle=%0d got=%b exp=%b", i, smp_wr_ready, ex_t[i] == 1);
         end
         if (ex_t[i] == 3) begin
            checks++;
            if (smp_we !== 1'b0 || smp_oe !== 1'b1) begin
               errors++; $display("FAIL arb_cap_bus cycle=%0d we=%b oe=%b exp=0/1", i, smp_we, smp_oe);
            end
         end
         prev = cls;
      end
      ifc.wr_valid = 1'b0;
      ifc.rd_ready = 1'b1;
      while (popped.size() < pushed.size() && n < 40) begin
         cyc();
         n++;
      end
      ifc.rd_ready = 1'b0;
      checks++;
      if (popped.size() != pushed.size()) begin
         errors++; $display("FAIL arb_drain got=%0d exp=%0d", popped.size(), pushed.size());
      end
      for (int i = 0; i < popped.size() && i < pushed.size(); i++) begin
         checks++;
         if (popped[i] !== pushed[i]) begin
            errors++; $display("FAIL arb_data idx=%0d got=%h exp=%h", i, popped[i], pushed[i]);
         end
      end
   endtask

   task automatic test_reset_rdcap();
      bit ok;
      do_reset();
      push_word(8'h11, ok);
      push_word(8'h22, ok);
      push_word(8'h33, ok);
      wait_rdv(ok);
      checks++;
      if (!ok || smp_rd_data !== 8'h11) begin
         errors++; $display("FAIL rcap_setup ok=%b data=%h exp=1/11", ok, smp_rd_data);
      end
      ifc.rd_ready = 1'b1;
      cyc();
      ifc.rd_ready = 1'b0;
      checks++;
      if ({smp_cs, smp_we, smp_oe} !== 3'b101) begin
         errors++; $display("FAIL rcap_issue ctl=%b exp=101", {smp_cs, smp_we, smp_oe});
      end
      checks++;
      if (ram_cs !== 1'b1 || ram_we !== 1'b0 || count !== 3'd1) begin
         errors++; $display("FAIL rcap_inflight cs=%b we=%b count=%0d exp=1/0/1", ram_cs, ram_we, count);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin
         errors++; $display("FAIL rcap_rst_ctl got=%b exp=000", {ram_cs, ram_we, ram_oe});
      end
      checks++;
      if (count !== 3'd0 || ifc.rd_valid !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL rcap_rst_status count=%0d rv=%b empty=%b exp=0/0/1", count, ifc.rd_valid, empty);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      pushed.delete();
      popped.delete();
      push_word(8'h3C, ok);
      wait_rdv(ok);
      checks++;
      if (!ok || smp_rd_data !== 8'h3C || smp_count !== 3'd1) begin
         errors++;
         $display("FAIL rcap_after ok=%b data=%h count=%0d exp=1/3c/1", ok, smp_rd_data, smp_count);
      end
   endtask

   task automatic test_random();
      int n = 0;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         ifc.wr_valid = (i < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
         ifc.rd_ready = (i < 40) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         ifc.wr_data  = 8'($urandom);
         cyc();
         checks++;
         if (!(int'(smp_count) == smp_size || int'(smp_count) == smp_size - 1)) begin
            errors++; $display("FAIL rnd_count cycle=%0d got=%0d exp=%0d_or_one_less", i, smp_count, smp_size);
         end
         checks++;
         if (smp_empty !== (smp_count == 3'd0)) begin
            errors++; $display("FAIL rnd_empty cycle=%0d got=%b count=%0d", i, smp_empty, smp_count);
         end
         checks++;
         if (smp_full && smp_wr_ready) begin
            errors++; $display("FAIL rnd_full_push cycle=%0d got=ready exp=blocked", i);
         end
         if (smp_cs && smp_we) begin
            checks++;
            if (smp_bus !== ifc.wr_data) begin
               errors++; $display("FAIL rnd_bus cycle=%0d got=%h exp=%h", i, smp_bus, ifc.wr_data);
            end
         end
      end
      ifc.wr_valid = 1'b0;
      ifc.rd_ready = 1'b1;
      while (popped.size() < pushed.size() && n < 40) begin
         cyc();
         n++;
      end
      ifc.rd_ready = 1'b0;
      checks++;
      if (popped.size() != pushed.size()) begin
         errors++; $display("FAIL rnd_drain got=%0d exp=%0d", popped.size(), pushed.size());
      end
      for (int i = 0; i < popped.size() && i < pushed.size(); i++) begin
         checks++;
         if (popped[i] !== pushed[i]) begin
            errors++; $display("FAIL rnd_data idx=%0d got=%h exp=%h", i, popped[i], pushed[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill();
      test_drain();
      test_arbitration();
      test_reset_rdcap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time_limit got=expired exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
